// File: rtl/alu_ctrl_sequencer_if.sv
// Handshake bundle between the decode stage, the ALU control sequencer and
// the ALU/vector datapath. The master side offers instructions and accepts
// beats; the slave side is the sequencer itself.
interface alu_ctrl_sequencer_if #(
   parameter int LANES = 4
);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [1:0]        alu_op;
   logic [10:0]       alu_instr;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        ctrl_out;
   logic [LANE_W-1:0] lane_idx;
   logic              is_vector;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;
   logic              illegal;
   logic              busy;

   modport master (
      output alu_op, alu_instr, in_valid, out_ready,
      input  in_ready, ctrl_out, lane_idx, is_vector, out_last, out_valid,
             illegal, busy
   );

   modport slave (
      input  alu_op, alu_instr, in_valid, out_ready,
      output in_ready, ctrl_out, lane_idx, is_vector, out_last, out_valid,
             illegal, busy
   );
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// ALU control sequencer: decodes alu_op/alu_instr into 4-bit ALU control
// codes, expands vector instructions into LANES per-lane beats and holds a
// MAC for MAC_LAT cycles before its single result beat. Beats leave through
// a one-entry output register with a valid/ready handshake.
module alu_ctrl_sequencer #(
   parameter int LANES   = 4,
   parameter int MAC_LAT = 3
) (
   input  logic                clk,
   input  logic                rst,
   alu_ctrl_sequencer_if.slave bus
);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNT_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [CNT_W-1:0]  MAC_LOAD  = CNT_W'(MAC_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]        MAC_CODE  = 4'b1000;

   typedef enum logic [1:0] {IDLE, VEC, MAC} state_t;
   typedef enum logic [1:0] {KIND_SCALAR, KIND_VECTOR, KIND_MAC, KIND_ILLEGAL} kind_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   kind_t             dec_kind;
   logic [3:0]        dec_code;

   logic [3:0]        ctrl_q;
   logic [LANE_W-1:0] lane_q;
   logic              vec_q;
   logic              last_q;
   logic              valid_q;
   logic              illegal_q;

   logic              load_ok;
   logic              in_ready;
   logic              accept;
   logic              mac_done;
   logic [LANE_W-1:0] lane_next;

   logic              load_beat;
   logic [3:0]        beat_ctrl;
   logic [LANE_W-1:0] beat_lane;
   logic              beat_vec;
   logic              beat_last;

   // The output register can take a new beat when empty or draining this cycle
   assign load_ok   = !valid_q || bus.out_ready;
   assign in_ready  = (state_q == IDLE) && load_ok;
   assign accept    = bus.in_valid && in_ready;
   assign lane_next = lane_q + LANE_W'(1);
   // The MAC beat is loaded on the edge where the counter steps from 1 to 0
   assign mac_done  = (cnt_q == CNT_ONE) || (cnt_q == '0);

   // Opcode decode: instruction class and ALU control code
   always_comb begin
      dec_kind = KIND_ILLEGAL;
      dec_code = 4'b0000;
      case (bus.alu_op)
         2'b00: begin dec_kind = KIND_SCALAR; dec_code = 4'b0010; end
         2'b01: begin dec_kind = KIND_SCALAR; dec_code = 4'b0111; end
         2'b10: begin
            case (bus.alu_instr)
               11'b10001011000: begin dec_kind = KIND_SCALAR; dec_code = 4'b0010; end
               11'b11001011000: begin dec_kind = KIND_SCALAR; dec_code = 4'b0110; end
               11'b10001010000: begin dec_kind = KIND_SCALAR; dec_code = 4'b0000; end
               11'b10101010000: begin dec_kind = KIND_SCALAR; dec_code = 4'b0001; end
               11'b10011010000: begin dec_kind = KIND_SCALAR; dec_code = 4'b0100; end
               11'b10111010000: begin dec_kind = KIND_SCALAR; dec_code = 4'b0101; end
               11'b10001010010: begin dec_kind = KIND_VECTOR; dec_code = 4'b0010; end
               11'b11001010010: begin dec_kind = KIND_VECTOR; dec_code = 4'b0110; end
               11'b10011010010: begin dec_kind = KIND_VECTOR; dec_code = 4'b0100; end
               11'b10001010100: begin dec_kind = KIND_VECTOR; dec_code = 4'b0010; end
               11'b10011110000: begin dec_kind = KIND_VECTOR; dec_code = 4'b0100; end
               11'b10001110000: begin dec_kind = KIND_VECTOR; dec_code = 4'b0010; end
               11'b11111010100: begin dec_kind = KIND_MAC;    dec_code = MAC_CODE; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // State register and MAC latency counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: vectors walk through VEC, multi-cycle MACs wait in MAC
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (dec_kind == KIND_VECTOR && LANES > 1) begin
                  state_d = VEC;
               end else if (dec_kind == KIND_MAC && MAC_LAT > 1) begin
                  state_d = MAC;
                  cnt_d   = MAC_LOAD;
               end
            end
         end
         VEC: begin
            if (load_ok && lane_next == LAST_LANE) begin
               state_d = IDLE;
            end
         end
         MAC: begin
            if (mac_done) begin
               if (load_ok) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: decide whether a beat is loaded this cycle and its contents
   always_comb begin
      load_beat = 1'b0;
      beat_ctrl = ctrl_q;
      beat_lane = '0;
      beat_vec  = 1'b0;
      beat_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (dec_kind)
                  KIND_SCALAR: begin
                     load_beat = 1'b1;
                     beat_ctrl = dec_code;
                     beat_last = 1'b1;
                  end
                  KIND_VECTOR: begin
                     load_beat = 1'b1;
                     beat_ctrl = dec_code;
                     beat_vec  = 1'b1;
                     beat_last = (LANES == 1);
                  end
                  KIND_MAC: begin
                     if (MAC_LAT == 1) begin
                        load_beat = 1'b1;
                        beat_ctrl = MAC_CODE;
                        beat_last = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         VEC: begin
            if (load_ok) begin
               load_beat = 1'b1;
               beat_lane = lane_next;
               beat_vec  = 1'b1;
               beat_last = (lane_next == LAST_LANE);
            end
         end
         MAC: begin
            if (mac_done && load_ok) begin
               load_beat = 1'b1;
               beat_ctrl = MAC_CODE;
               beat_last = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Output register: holds a beat stable until the datapath takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= 4'b0000;
         lane_q    <= '0;
         vec_q     <= 1'b0;
         last_q    <= 1'b0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= accept && (dec_kind == KIND_ILLEGAL);
         if (load_beat) begin
            ctrl_q  <= beat_ctrl;
            lane_q  <= beat_lane;
            vec_q   <= beat_vec;
            last_q  <= beat_last;
            valid_q <= 1'b1;
         end else if (bus.out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.ctrl_out  = ctrl_q;
   assign bus.lane_idx  = lane_q;
   assign bus.is_vector = vec_q;
   assign bus.out_last  = last_q;
   assign bus.out_valid = valid_q;
   assign bus.illegal   = illegal_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer (LANES=4, MAC_LAT=3). Expected
// beats are pushed into a scoreboard queue when an instruction is offered and
// popped by a monitor whenever the DUT hands a beat over.
module tb_alu_ctrl_sequencer;
   localparam int LANES   = 4;
   localparam int MAC_LAT = 3;
   localparam int LANE_W  = 2;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_VADD = 11'b10001010010;
   localparam logic [10:0] OP_VSUB = 11'b11001010010;
   localparam logic [10:0] OP_VMUL = 11'b10011010010;
   localparam logic [10:0] OP_VMOV = 11'b10001010100;
   localparam logic [10:0] OP_MAC  = 11'b11111010100;

   typedef struct packed {
      logic [3:0]        ctrl;
      logic [LANE_W-1:0] lane;
      logic              vec;
      logic              last;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    n_compared   = 0;
   int    n_mismatched = 0;
   beat_t sb[$];
   beat_t exp_b;

   alu_ctrl_sequencer_if #(.LANES(LANES)) bus ();

   alu_ctrl_sequencer #(.LANES(LANES), .MAC_LAT(MAC_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Reference decode: pushes the beats an instruction must produce
   function automatic void expect_instr(input logic [1:0] op, input logic [10:0] instr);
      beat_t      b;
      logic [3:0] code;
      int         kind;
      kind = 3;
      code = 4'b0000;
      if (op == 2'b00) begin kind = 0; code = 4'b0010; end
      else if (op == 2'b01) begin kind = 0; code = 4'b0111; end
      else if (op == 2'b10) begin
         case (instr)
            11'b10001011000: begin kind = 0; code = 4'b0010; end
            11'b11001011000: begin kind = 0; code = 4'b0110; end
            11'b10001010000: begin kind = 0; code = 4'b0000; end
            11'b10101010000: begin kind = 0; code = 4'b0001; end
            11'b10011010000: begin kind = 0; code = 4'b0100; end
            11'b10111010000: begin kind = 0; code = 4'b0101; end
            11'b10001010010: begin kind = 1; code = 4'b0010; end
            11'b11001010010: begin kind = 1; code = 4'b0110; end
            11'b10011010010: begin kind = 1; code = 4'b0100; end
            11'b10001010100: begin kind = 1; code = 4'b0010; end
            11'b10011110000: begin kind = 1; code = 4'b0100; end
            11'b10001110000: begin kind = 1; code = 4'b0010; end
            11'b11111010100: begin kind = 2; code = 4'b1000; end
            default: kind = 3;
         endcase
      end
      b.ctrl = code;
      b.lane = '0;
      b.vec  = 1'b0;
      b.last = 1'b1;
      if (kind == 0 || kind == 2) begin
         sb.push_back(b);
      end else if (kind == 1) begin
         for (int l = 0; l < LANES; l++) begin
            b.lane = LANE_W'(l);
            b.vec  = 1'b1;
            b.last = (l == LANES - 1);
            sb.push_back(b);
         end
      end
   endfunction

   // Monitor: every beat handed over must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_compared++;
         if (sb.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL unexpected_beat: got ctrl=%b lane=%0d vec=%b last=%b, expected no beat",
                     bus.ctrl_out, bus.lane_idx, bus.is_vector, bus.out_last);
         end else begin
            exp_b = sb.pop_front();
            if ({bus.ctrl_out, bus.lane_idx, bus.is_vector, bus.out_last} !== exp_b) begin
               n_mismatched++;
               $display("[TB] FAIL beat: got ctrl=%b lane=%0d vec=%b last=%b, expected ctrl=%b lane=%0d vec=%b last=%b",
                        bus.ctrl_out, bus.lane_idx, bus.is_vector, bus.out_last,
                        exp_b.ctrl, exp_b.lane, exp_b.vec, exp_b.last);
            end
         end
      end
   end

   // Offer one instruction (called at posedge+1), return at posedge+1 after accept
   task automatic send(input logic [1:0] op, input logic [10:0] instr, input string name);
      bit seen;
      seen          = 1'b0;
      bus.alu_op    = op;
      bus.alu_instr = instr;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = bus.in_ready;
         @(posedge clk);
         #1;
      end
      n_compared++;
      if (!seen) begin
         n_mismatched++;
         $display("[TB] FAIL %s_accept: got no accept in 40 cycles, expected accept", name);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] obs;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.alu_op    = 2'b00;
      bus.alu_instr = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      obs = {bus.ctrl_out, bus.lane_idx, bus.is_vector, bus.out_last, bus.out_valid, bus.illegal, bus.busy};
      n_compared++;
      if (obs !== 11'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_outputs: got %b, expected all zero", obs);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_compared++;
      if (bus.in_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      expect_instr(2'b10, OP_ADD);
      send(2'b10, OP_ADD, "add");
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b1 || bus.ctrl_out !== 4'b0010 || bus.out_last !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL add_beat: got valid=%b ctrl=%b last=%b, expected valid=1 ctrl=0010 last=1",
                  bus.out_valid, bus.ctrl_out, bus.out_last);
      end
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL add_single_cycle: got valid=%b, expected 0", bus.out_valid);
      end
      @(posedge clk);
      #1;
      n_compared++;
      if (sb.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL add_drain: got %0d beats pending, expected 0", sb.size());
      end
   endtask

   task automatic test_vector_burst();
      bus.out_ready = 1'b1;
      expect_instr(2'b10, OP_VSUB);
      send(2'b10, OP_VSUB, "vsub");
      for (int i = 0; i < LANES; i++) begin
         @(negedge clk);
         n_compared++;
         if (bus.out_valid !== 1'b1 || bus.lane_idx !== LANE_W'(i)) begin
            n_mismatched++;
            $display("[TB] FAIL vsub_lane: got valid=%b lane=%0d, expected valid=1 lane=%0d",
                     bus.out_valid, bus.lane_idx, i);
         end
         n_compared++;
         if (bus.in_ready !== (i == LANES - 1) || bus.busy !== (i < LANES - 1)) begin
            n_mismatched++;
            $display("[TB] FAIL vsub_ready: got in_ready=%b busy=%b at lane %0d, expected in_ready=%b busy=%b",
                     bus.in_ready, bus.busy, i, (i == LANES - 1), (i < LANES - 1));
         end
      end
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL vsub_end: got valid=%b, expected 0", bus.out_valid);
      end
      @(posedge clk);
      #1;
      n_compared++;
      if (sb.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL vsub_drain: got %0d beats pending, expected 0", sb.size());
      end
   endtask

   task automatic test_stall();
      bit pat   [6];
      int lanes [6];
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      lanes = '{0, 1, 1, 1, 2, 3};
      bus.out_ready = 1'b1;
      expect_instr(2'b10, OP_VMUL);
      send(2'b10, OP_VMUL, "vmul");
      for (int i = 0; i < 6; i++) begin
         bus.out_ready = pat[i];
         @(negedge clk);
         n_compared++;
         if (bus.out_valid !== 1'b1 || bus.lane_idx !== LANE_W'(lanes[i]) || bus.ctrl_out !== 4'b0100) begin
            n_mismatched++;
            $display("[TB] FAIL vmul_stall: got valid=%b lane=%0d ctrl=%b at cycle %0d, expected valid=1 lane=%0d ctrl=0100",
                     bus.out_valid, bus.lane_idx, bus.ctrl_out, i, lanes[i]);
         end
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL vmul_count: got valid=%b pending=%0d, expected valid=0 pending=0",
                  bus.out_valid, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mac_back_to_back();
      bus.out_ready = 1'b1;
      expect_instr(2'b10, OP_MAC);
      send(2'b10, OP_MAC, "mac");
      for (int i = 0; i < MAC_LAT - 1; i++) begin
         @(negedge clk);
         n_compared++;
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mac_wait: got valid=%b busy=%b in_ready=%b at cycle %0d, expected 0/1/0",
                     bus.out_valid, bus.busy, bus.in_ready, i);
         end
         @(posedge clk);
         #1;
      end
      expect_instr(2'b10, OP_ADD);
      bus.alu_op    = 2'b10;
      bus.alu_instr = OP_ADD;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b1 || bus.ctrl_out !== 4'b1000 || bus.in_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL mac_beat: got valid=%b ctrl=%b in_ready=%b, expected valid=1 ctrl=1000 in_ready=1",
                  bus.out_valid, bus.ctrl_out, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b1 || bus.ctrl_out !== 4'b0010) begin
         n_mismatched++;
         $display("[TB] FAIL mac_then_add: got valid=%b ctrl=%b, expected valid=1 ctrl=0010",
                  bus.out_valid, bus.ctrl_out);
      end
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL mac_drain: got valid=%b pending=%0d, expected valid=0 pending=0",
                  bus.out_valid, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      expect_instr(2'b10, 11'b11111111111);
      send(2'b10, 11'b11111111111, "bad_opcode");
      @(negedge clk);
      n_compared++;
      if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL bad_opcode_pulse: got illegal=%b valid=%b in_ready=%b, expected 1/0/1",
                  bus.illegal, bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      n_compared++;
      if (bus.illegal !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL bad_opcode_end: got illegal=%b valid=%b, expected 0/0", bus.illegal, bus.out_valid);
      end
      @(posedge clk);
      #1;
      expect_instr(2'b11, OP_ADD);
      send(2'b11, OP_ADD, "bad_aluop");
      @(negedge clk);
      n_compared++;
      if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL bad_aluop_pulse: got illegal=%b valid=%b in_ready=%b, expected 1/0/1",
                  bus.illegal, bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      n_compared++;
      if (bus.illegal !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL bad_aluop_end: got illegal=%b valid=%b busy=%b, expected 0/0/0",
                  bus.illegal, bus.out_valid, bus.busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_vector();
      logic [10:0] obs;
      bus.out_ready = 1'b1;
      expect_instr(2'b10, OP_VADD);
      send(2'b10, OP_VADD, "vadd");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_compared++;
         if (bus.lane_idx !== LANE_W'(i) || bus.out_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL vadd_lane: got valid=%b lane=%0d, expected valid=1 lane=%0d",
                     bus.out_valid, bus.lane_idx, i);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      obs = {bus.ctrl_out, bus.lane_idx, bus.is_vector, bus.out_last, bus.out_valid, bus.illegal, bus.busy};
      n_compared++;
      if (obs !== 11'b0 || bus.in_ready !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL async_reset: got outputs=%b in_ready=%b, expected zero and in_ready=1",
                  obs, bus.in_ready);
      end
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_instr(2'b10, OP_VMOV);
      send(2'b10, OP_VMOV, "vmov");
      for (int i = 0; i < LANES; i++) begin
         @(negedge clk);
         n_compared++;
         if (bus.lane_idx !== LANE_W'(i) || bus.out_valid !== 1'b1 || bus.is_vector !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL vmov_lane: got valid=%b lane=%0d vec=%b, expected valid=1 lane=%0d vec=1",
                     bus.out_valid, bus.lane_idx, bus.is_vector, i);
         end
      end
      @(negedge clk);
      n_compared++;
      if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL vmov_drain: got valid=%b pending=%0d, expected valid=0 pending=0",
                  bus.out_valid, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Scenario sequence
   initial begin
      bus.in_valid  = 1'b0;
      bus.alu_op    = 2'b00;
      bus.alu_instr = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_vector_burst();
      test_stall();
      test_mac_back_to_back();
      test_illegal();
      test_reset_mid_vector();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Watchdog against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
- Parametrised successor to the combinational ALU control decoder.
- Decodes the same opcode and ALU_Op space into 4-bit ALU control codes.
- Sequences vector instructions into LANES per-lane beats and holds MAC for a fixed latency.
- Sits between the instruction decode stage and the ALU/vector datapath, with valid/ready handshakes on both sides.

Parameters:
LANES, 4, number of vector lanes (beats per vector instruction); minimum 1.
MAC_LAT, 3, cycles a MAC occupies before its single result beat; minimum 1.
LANE_W, $clog2(LANES) with a minimum of 1, localparam, lane index width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
alu_op  input  2  ALU operation class from the main control.
alu_instr  input  11  opcode field.
in_valid  input  1  instruction offered.
in_ready  output  1  sequencer can accept an instruction.
ctrl_out  output  4  ALU control code for the current beat.
lane_idx  output  LANE_W  lane of the current beat.
is_vector  output  1  current beat belongs to a vector instruction.
out_last  output  1  final beat of the instruction.
out_valid  output  1  beat valid.
out_ready  input  1  datapath accepts the beat.
illegal  output  1  one-cycle pulse: undecodable instruction was accepted.
busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - Registered outputs go to 0: ctrl_out, lane_idx, is_vector, out_last, out_valid, illegal, busy.
  - state = IDLE; counters = 0. Any in-flight instruction is discarded.
- in_ready = (state==IDLE) && (!out_valid || out_ready); combinational. An accept is in_valid && in_ready.
- Decode classes:
  - alu_op 00: scalar, code 0010.
  - alu_op 01: scalar, code 0111.
  - alu_op 11: illegal.
- alu_op 10 decodes on alu_instr:
  - ADD 10001011000 -> 0010, scalar.
  - SUB 11001011000 -> 0110, scalar.
  - AND 10001010000 -> 0000, scalar.
  - ORR 10101010000 -> 0001, scalar.
  - MUL 10011010000 -> 0100, scalar.
  - MOV 10111010000 -> 0101, scalar.
  - VADD 10001010010 -> 0010, vector.
  - VSUB 11001010010 -> 0110, vector.
  - VMUL 10011010010 -> 0100, vector.
  - VMOV 10001010100 -> 0010, vector.
  - VLD1 10011110000 -> 0100, vector.
  - VST1 10001110000 -> 0010, vector.
  - MAC 11111010100 -> 1000, MAC.
  - Any other opcode: illegal.
- States: IDLE, VEC, MAC.
- Output register:
  - Loads a new beat only when !out_valid || out_ready.
  - ctrl_out, lane_idx, is_vector and out_last stay stable while out_valid && !out_ready.
  - out_valid clears after a handshake when no new beat is loaded.
- Scalar accept: next cycle out_valid=1, lane_idx=0, is_vector=0, out_last=1. State stays IDLE. Throughput is 1 instruction/cycle when out_ready is held high.
- Vector accept:
  - Next cycle: beat lane 0, is_vector=1, out_last=(LANES==1). If LANES>1, state -> VEC.
  - In VEC, each out_ready handshake loads lane+1.
  - Loading lane LANES-1 sets out_last=1 and state -> IDLE.
  - Lanes never skip or repeat. lane_idx does not wrap beyond LANES-1.
- MAC accept:
  - state -> MAC; counter loads MAC_LAT-1. out_valid=0 while counting, except for draining a previously loaded beat.
  - At counter 0 with the output register free: beat ctrl 1000, lane 0, is_vector=0, out_last=1; state -> IDLE.
  - MAC_LAT=1: behaves as a scalar with latency 1.
- Illegal accept: no beat is produced. illegal=1 for exactly the next cycle. State stays IDLE. The instruction is consumed.
- busy = (state!=IDLE).
- Simultaneous final-beat handshake and new accept: legal. The new instruction's first beat appears the following cycle with no bubble.

Test Plan:
- rst held then released, out_ready=1 -> all outputs 0, in_ready=1. Then ADD -> next cycle ctrl_out=0010, out_last=1, out_valid=1 for 1 cycle.
- LANES=4, VSUB with out_ready=1 -> 4 consecutive beats ctrl 0110, lane 0,1,2,3, out_last only on lane 3. in_ready=0 until lane 3 is loaded.
- VMUL with out_ready toggling 1,0,0,1,1,1 -> each lane is held stable while stalled. Exactly 4 beats are transferred; no lane is duplicated or skipped.
- MAC_LAT=3, MAC -> out_valid=0 and busy=1 for 2 cycles, then one beat ctrl 1000 with out_last=1. A following ADD is accepted on the same cycle the MAC beat is handshaked.
- alu_op=10, alu_instr=11111111111, then alu_op=11 -> illegal pulses 1 cycle each, no out_valid, in_ready remains 1.
- rst asserted asynchronously during lane 2 of VADD -> outputs 0 immediately, state IDLE. After release, a new VMOV starts at lane 0.
